// File: rtl/eight_bit_divider_if.sv
// Handshake and display bundle for the eight-bit restoring divider.
// Directions are named from the divider's point of view (_i into it, _o out of it).
interface eight_bit_divider_if;
  logic       run_i;
  logic       clear_a_load_b_i;
  logic [7:0] s_i;
  logic [7:0] aval_o;
  logic [7:0] bval_o;
  logic [6:0] ahex_u_o;
  logic [6:0] ahex_l_o;
  logic [6:0] bhex_u_o;
  logic [6:0] bhex_l_o;
  logic       busy_o;
  logic       done_o;
  logic       div_zero_o;

  modport master (
    output run_i, clear_a_load_b_i, s_i,
    input  aval_o, bval_o, ahex_u_o, ahex_l_o, bhex_u_o, bhex_l_o,
           busy_o, done_o, div_zero_o
  );

  modport slave (
    input  run_i, clear_a_load_b_i, s_i,
    output aval_o, bval_o, ahex_u_o, ahex_l_o, bhex_u_o, bhex_l_o,
           busy_o, done_o, div_zero_o
  );
endinterface

// File: rtl/eight_bit_divider.sv
// Unsigned 8-bit restoring divider: quotient ends in B, remainder in A,
// one shift/subtract pair per quotient bit, with 7-segment views of both registers.
module eight_bit_divider (
  input  logic                       clk_i,
  input  logic                       rst_i,
  eight_bit_divider_if.slave         bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_SUB   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0] state_q, state_d;
  logic [8:0] r_q, r_d;
  logic [7:0] b_q, b_d;
  logic [7:0] d_q, d_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dz_q, dz_d;
  logic [9:0] diff_s;

  // Active-low seven-segment pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Trial subtraction; bit 9 set means the divisor did not fit.
  assign diff_s = {1'b0, r_q} - {2'b00, d_q};

  // Next-state and datapath decisions for the divider FSM.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    b_d     = b_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear_a_load_b_i) begin
          b_d  = bus.s_i;
          r_d  = 9'd0;
          dz_d = 1'b0;
        end else if (bus.run_i) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        d_d   = bus.s_i;
        r_d   = 9'd0;
        cnt_d = 3'd0;
        if (bus.s_i == 8'd0) begin
          // Divide-by-zero: saturate the quotient and return the dividend as remainder.
          b_d     = 8'hFF;
          r_d     = {1'b0, b_q};
          dz_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          dz_d    = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {r_d, b_d} = {r_q[7:0], b_q, 1'b0};
        state_d    = ST_SUB;
      end
      ST_SUB: begin
        if (diff_s[9] == 1'b0) begin
          r_d    = diff_s[8:0];
          b_d[0] = 1'b1;
        end else begin
          r_d = r_q;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // Wait for Run to drop so a held button yields a single division.
        if (bus.run_i) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      r_q     <= 9'd0;
      b_q     <= 8'd0;
      d_q     <= 8'd0;
      cnt_q   <= 3'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      b_q     <= b_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.aval_o     = r_q[7:0];
  assign bus.bval_o     = b_q;
  assign bus.ahex_u_o   = hex7(r_q[7:4]);
  assign bus.ahex_l_o   = hex7(r_q[3:0]);
  assign bus.bhex_u_o   = hex7(b_q[7:4]);
  assign bus.bhex_l_o   = hex7(b_q[3:0]);
  assign bus.busy_o     = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_SUB);
  assign bus.done_o     = (state_q == ST_DONE);
  assign bus.div_zero_o = dz_q;

endmodule

// File: tb/tb_eight_bit_divider.sv
// Randomized self-checking bench for eight_bit_divider against an arithmetic
// quotient/remainder model, plus the directed corner cases.
module tb_eight_bit_divider;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [7:0] model_b;
  logic [6:0] seg_tbl [16];

  eight_bit_divider_if bus ();

  eight_bit_divider dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_hex(input logic [7:0] a, input logic [7:0] b);
    check_val("ahex_u", {25'd0, bus.ahex_u_o}, {25'd0, seg_tbl[a[7:4]]});
    check_val("ahex_l", {25'd0, bus.ahex_l_o}, {25'd0, seg_tbl[a[3:0]]});
    check_val("bhex_u", {25'd0, bus.bhex_u_o}, {25'd0, seg_tbl[b[7:4]]});
    check_val("bhex_l", {25'd0, bus.bhex_l_o}, {25'd0, seg_tbl[b[3:0]]});
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    bus.clear_a_load_b_i = 1'b1;
    bus.s_i              = v;
    @(posedge clk); #1;
    check_val("load_b",  {24'd0, bus.bval_o}, {24'd0, v});
    check_val("load_a",  {24'd0, bus.aval_o}, 32'd0);
    check_val("load_dz", {31'd0, bus.div_zero_o}, 32'd0);
    check_val("load_busy", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);
    bus.clear_a_load_b_i = 1'b0;
    model_b = v;
  endtask

  // One press of Run; hold keeps Run high that many extra cycles after Done.
  task automatic do_run(input logic [7:0] div, input int hold, input bit noise);
    int         edges;
    bit         seen;
    int         exp_q, exp_r, exp_lat;
    logic [7:0] q8, r8;
    if (div == 8'd0) begin
      exp_q = 255; exp_r = int'(model_b); exp_lat = 2;
    end else begin
      exp_q = int'(model_b) / int'(div);
      exp_r = int'(model_b) % int'(div);
      exp_lat = 18;
    end
    q8 = exp_q[7:0];
    r8 = exp_r[7:0];
    @(negedge clk);
    bus.run_i            = 1'b1;
    bus.s_i              = div;
    bus.clear_a_load_b_i = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk); edges++; #1;
      if (bus.done_o) seen = 1'b1;
      if (edges == 1) check_val("busy_load", {31'd0, bus.busy_o}, 32'd1);
      if (noise && edges >= 2 && !seen) begin
        bus.s_i              = 8'($urandom);
        bus.clear_a_load_b_i = 1'($urandom);
      end
    end
    bus.clear_a_load_b_i = 1'b0;
    check_val("done_seen", {31'd0, seen}, 32'd1);
    check_val("latency",   edges, exp_lat);
    check_val("quotient",  {24'd0, bus.bval_o}, {24'd0, q8});
    check_val("remainder", {24'd0, bus.aval_o}, {24'd0, r8});
    check_val("divzero",   {31'd0, bus.div_zero_o}, {31'd0, div == 8'd0});
    check_val("busy_done", {31'd0, bus.busy_o}, 32'd0);
    check_hex(r8, q8);
    repeat (hold) @(posedge clk);
    #1;
    check_val("hold_done", {31'd0, bus.done_o}, 32'd1);
    check_val("hold_b",    {24'd0, bus.bval_o}, {24'd0, q8});
    @(negedge clk);
    bus.run_i = 1'b0;
    @(posedge clk); #1;
    check_val("idle_done", {31'd0, bus.done_o}, 32'd0);
    check_val("idle_busy", {31'd0, bus.busy_o}, 32'd0);
    model_b = q8;
  endtask

  initial begin
    seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001; seg_tbl[2]  = 7'b0100100;
    seg_tbl[3]  = 7'b0110000; seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
    seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000; seg_tbl[8]  = 7'b0000000;
    seg_tbl[9]  = 7'b0010000; seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
    seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001; seg_tbl[14] = 7'b0000110;
    seg_tbl[15] = 7'b0001110;
    n_checks = 0;
    n_errors = 0;
    model_b  = 8'd0;
    bus.run_i            = 1'b0;
    bus.clear_a_load_b_i = 1'b0;
    bus.s_i              = 8'd0;
    rst = 1'b1;
    #12;
    check_val("rst_a",    {24'd0, bus.aval_o}, 32'd0);
    check_val("rst_b",    {24'd0, bus.bval_o}, 32'd0);
    check_val("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check_val("rst_done", {31'd0, bus.done_o}, 32'd0);
    check_val("rst_dz",   {31'd0, bus.div_zero_o}, 32'd0);
    check_hex(8'd0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    do_load(8'd100); do_run(8'd7, 0, 1'b0);
    do_load(8'd255); do_run(8'd1, 0, 1'b0);
    do_load(8'd5);   do_run(8'd9, 0, 1'b0);
    do_load(8'hC8);  do_run(8'd0, 2, 1'b1);
    do_load(8'h11);
    do_load(8'd100); do_run(8'd7, 40, 1'b0);
    do_run(8'd2, 0, 1'b0);

    // Load and Run together: load wins, FSM stays idle.
    @(negedge clk);
    bus.clear_a_load_b_i = 1'b1;
    bus.run_i            = 1'b1;
    bus.s_i              = 8'h30;
    @(posedge clk); #1;
    check_val("both_b",    {24'd0, bus.bval_o}, 32'h30);
    check_val("both_a",    {24'd0, bus.aval_o}, 32'd0);
    check_val("both_busy", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);
    bus.clear_a_load_b_i = 1'b0;
    bus.run_i            = 1'b0;
    @(posedge clk); #1;
    check_val("both_busy2", {31'd0, bus.busy_o}, 32'd0);
    model_b = 8'h30;

    // Randomized divisions, some chained on the previous quotient.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] dv;
      if ($urandom_range(0, 3) != 0) do_load(8'($urandom));
      dv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      do_run(dv, int'($urandom_range(0, 3)), 1'b1);
    end

    // Asynchronous reset in the SUB state of bit 3.
    do_load(8'd200);
    @(negedge clk);
    bus.run_i = 1'b1;
    bus.s_i   = 8'd3;
    repeat (9) @(posedge clk);
    #2;
    check_val("mid_busy_pre", {31'd0, bus.busy_o}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("mid_a",    {24'd0, bus.aval_o}, 32'd0);
    check_val("mid_b",    {24'd0, bus.bval_o}, 32'd0);
    check_val("mid_done", {31'd0, bus.done_o}, 32'd0);
    check_val("mid_busy", {31'd0, bus.busy_o}, 32'd0);
    check_hex(8'd0, 8'd0);
    bus.run_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_b = 8'd0;
    do_load(8'd77); do_run(8'd10, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
